// File: rtl/ifmap_stream_writer_pkg.sv
// Shared definitions for the IFMap producer: row-framing tags and writer FSM states.
// The tag values are also decoded by the Processing_element on the drain side.
package ifmap_stream_writer_pkg;

    localparam logic [1:0] TAG_MID    = 2'b00;
    localparam logic [1:0] TAG_LAST   = 2'b01;
    localparam logic [1:0] TAG_FIRST  = 2'b10;
    localparam logic [1:0] TAG_SINGLE = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_LOAD,
        ST_PUSH,
        ST_DONE
    } state_t;

endpackage

// File: rtl/ifmap_tag_counter.sv
// Row/column position tracker for the IFMap stream: produces the framing tag of the
// element currently being pushed and flags the final element of the transfer.
module ifmap_tag_counter
    import ifmap_stream_writer_pkg::*;
#(
    parameter int LEN_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_clear,
    input  logic                 i_adv,
    input  logic [LEN_WIDTH-1:0] i_row_len,
    input  logic [LEN_WIDTH-1:0] i_num_rows,
    output logic [1:0]           o_tag,
    output logic                 o_last
);

    logic [LEN_WIDTH-1:0] r_col;
    logic [LEN_WIDTH-1:0] r_row;
    logic                 w_col_end;
    logic                 w_row_end;

    assign w_col_end = (r_col == i_row_len - LEN_WIDTH'(1));
    assign w_row_end = (r_row == i_num_rows - LEN_WIDTH'(1));
    assign o_last    = w_col_end && w_row_end;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_clear) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_adv) begin
            if (w_col_end) begin
                r_col <= '0;
                r_row <= r_row + LEN_WIDTH'(1);
            end else begin
                r_col <= r_col + LEN_WIDTH'(1);
            end
        end
    end

    // A one-element row is both first and last, so it takes precedence.
    always_comb begin
        o_tag = TAG_MID;
        if (i_row_len == LEN_WIDTH'(1))
            o_tag = TAG_SINGLE;
        else if (r_col == '0)
            o_tag = TAG_FIRST;
        else if (w_col_end)
            o_tag = TAG_LAST;
    end

endmodule

// File: rtl/ifmap_stream_writer.sv
// IFMap producer: reads a row-major feature map from synchronous memory one element at a
// time and pushes each word, tagged with row framing, into the IFMap circular buffer.
module ifmap_stream_writer
    import ifmap_stream_writer_pkg::*;
#(
    parameter int DATA_WIDTH = 20,
    parameter int ADDR_WIDTH = 5,
    parameter int LEN_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  row_len,
    input  logic [LEN_WIDTH-1:0]  num_rows,
    output logic                  mem_ren,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  buf_ready,
    output logic                  buf_wen,
    output logic [DATA_WIDTH+1:0] buf_din,
    output logic                  busy,
    output logic                  done
);

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_hold;
    logic [LEN_WIDTH-1:0]  r_row_len;
    logic [LEN_WIDTH-1:0]  r_num_rows;
    logic                  r_mem_ren;
    logic                  r_busy;
    logic                  r_done;
    logic                  w_clear;
    logic                  w_push;
    logic                  w_last;
    logic [1:0]            w_tag;

    assign w_clear  = (r_state == ST_IDLE) && start;
    assign w_push   = (r_state == ST_PUSH) && buf_ready;

    assign mem_ren  = r_mem_ren;
    assign mem_addr = r_addr;
    assign busy     = r_busy;
    assign done     = r_done;
    assign buf_wen  = w_push;
    assign buf_din  = (r_state == ST_PUSH) ? {w_tag, r_hold} : '0;

    ifmap_tag_counter #(
        .LEN_WIDTH (LEN_WIDTH)
    ) u_tag_counter (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_clear),
        .i_adv      (w_push),
        .i_row_len  (r_row_len),
        .i_num_rows (r_num_rows),
        .o_tag      (w_tag),
        .o_last     (w_last)
    );

    // Outputs are set on the edge that enters their state so they stay glitch-free.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_hold     <= '0;
            r_row_len  <= '0;
            r_num_rows <= '0;
            r_mem_ren  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_addr     <= base_addr;
                        r_row_len  <= row_len;
                        r_num_rows <= num_rows;
                        if (row_len == '0 || num_rows == '0) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state   <= ST_READ;
                            r_mem_ren <= 1'b1;
                            r_busy    <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    r_mem_ren <= 1'b0;
                    r_state   <= ST_LOAD;
                end
                ST_LOAD: begin
                    r_hold  <= mem_rdata;
                    r_state <= ST_PUSH;
                end
                ST_PUSH: begin
                    if (buf_ready) begin
                        r_addr <= r_addr + ADDR_WIDTH'(1);
                        if (w_last) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state   <= ST_READ;
                            r_mem_ren <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_mem_ren <= 1'b0;
                    r_busy    <= 1'b0;
                    r_done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifmap_stream_writer.sv
// Self-checking bench for ifmap_stream_writer: a schedule model predicts, per cycle, every
// read, write, tag, busy and done value from the transfer rules and the buf_ready pattern.
module tb_ifmap_stream_writer;

    localparam int DW   = 20;
    localparam int AW   = 5;
    localparam int LW   = 5;
    localparam int MAXC = 400;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [LW-1:0] row_len = '0;
    logic [LW-1:0] num_rows = '0;
    logic          mem_ren;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata = '0;
    logic          buf_ready = 1'b1;
    logic          buf_wen;
    logic [DW+1:0] buf_din;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem [32];
    bit            rdy      [MAXC];
    bit            exp_wen  [MAXC];
    bit            exp_ren  [MAXC];
    bit            exp_busy [MAXC];
    bit            exp_done [MAXC];
    bit            exp_hold [MAXC];
    logic [AW-1:0] exp_addr [MAXC];
    logic [DW+1:0] exp_din  [MAXC];
    int            ncyc;
    int            exp_last;

    ifmap_stream_writer #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .LEN_WIDTH  (LW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .row_len   (row_len),
        .num_rows  (num_rows),
        .mem_ren   (mem_ren),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .buf_ready (buf_ready),
        .buf_wen   (buf_wen),
        .buf_din   (buf_din),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Synchronous memory: data is valid the cycle after the read enable.
    always @(posedge clk) if (mem_ren) mem_rdata <= mem[mem_addr];

    // Element k is fetched 2 cycles before it can first be offered; it is written on the
    // first ready cycle from then on, and the next element may be offered 3 cycles later.
    task automatic build_model(input int base, input int rl, input int nr);
        int e;
        int t;
        int a;
        int col;
        logic [1:0] tag;
        for (int i = 0; i < MAXC; i++) begin
            exp_wen[i] = 0; exp_ren[i] = 0; exp_busy[i] = 0;
            exp_done[i] = 0; exp_hold[i] = 0; exp_addr[i] = '0; exp_din[i] = '0;
        end
        if (rl * nr == 0) begin
            exp_done[1] = 1;
            exp_last = 0;
            ncyc = 4;
            return;
        end
        e = 3;
        t = 3;
        for (int k = 0; k < rl * nr; k++) begin
            a   = (base + k) % 32;
            col = k % rl;
            tag = (rl == 1) ? 2'b11 : (col == 0) ? 2'b10 : (col == rl - 1) ? 2'b01 : 2'b00;
            exp_ren[e - 2]  = 1;
            exp_addr[e - 2] = a[AW-1:0];
            t = e;
            while (!rdy[t]) begin
                exp_hold[t] = 1;
                exp_din[t]  = {tag, mem[a]};
                t++;
            end
            exp_wen[t] = 1;
            exp_din[t] = {tag, mem[a]};
            e = t + 3;
        end
        exp_last = t;
        for (int c = 1; c <= t; c++) exp_busy[c] = 1;
        exp_done[t + 1] = 1;
        ncyc = t + 4;
    endtask

    // rmode: 0 always ready, 1 not ready in cycles 6..9, 2 random readiness.
    task automatic test_stream(input string name, input int base, input int rl, input int nr,
                               input int rmode, input bit extra);
        for (int t = 0; t < MAXC; t++)
            rdy[t] = (t >= MAXC / 2) ? 1'b1 :
                     (rmode == 0)    ? 1'b1 :
                     (rmode == 1)    ? !(t >= 6 && t <= 9) :
                                       ($urandom_range(0, 2) != 0);
        build_model(base, rl, nr);
        for (int t = 0; t < ncyc; t++) begin
            @(posedge clk);
            #1;
            if (t == 0) begin
                start     = 1'b1;
                base_addr = AW'(base);
                row_len   = LW'(rl);
                num_rows  = LW'(nr);
            end else begin
                // Inputs wander after cycle 0; a busy writer must ignore them.
                start     = extra && (t % 4 == 2) && (t <= exp_last);
                base_addr = AW'($urandom);
                row_len   = LW'($urandom);
                num_rows  = LW'($urandom);
            end
            buf_ready = rdy[t];
            #1;
            checks++;
            if (mem_ren !== exp_ren[t]) begin
                errors++;
                $display("FAIL %s mem_ren cycle %0d got %b expected %b", name, t, mem_ren, exp_ren[t]);
            end
            if (exp_ren[t]) begin
                checks++;
                if (mem_addr !== exp_addr[t]) begin
                    errors++;
                    $display("FAIL %s mem_addr cycle %0d got %0d expected %0d", name, t, mem_addr, exp_addr[t]);
                end
            end
            checks++;
            if (buf_wen !== exp_wen[t]) begin
                errors++;
                $display("FAIL %s buf_wen cycle %0d got %b expected %b", name, t, buf_wen, exp_wen[t]);
            end
            if (exp_wen[t] || exp_hold[t]) begin
                checks++;
                if (buf_din !== exp_din[t]) begin
                    errors++;
                    $display("FAIL %s buf_din cycle %0d got %h expected %h", name, t, buf_din, exp_din[t]);
                end
            end
            checks++;
            if (busy !== exp_busy[t]) begin
                errors++;
                $display("FAIL %s busy cycle %0d got %b expected %b", name, t, busy, exp_busy[t]);
            end
            checks++;
            if (done !== exp_done[t]) begin
                errors++;
                $display("FAIL %s done cycle %0d got %b expected %b", name, t, done, exp_done[t]);
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({mem_ren, buf_wen, busy, done} !== 4'b0000) begin
            errors++;
            $display("FAIL reset ctrl got %b expected 0000", {mem_ren, buf_wen, busy, done});
        end
        checks++;
        if (buf_din !== '0) begin
            errors++;
            $display("FAIL reset buf_din got %h expected 0", buf_din);
        end
        checks++;
        if (mem_addr !== '0) begin
            errors++;
            $display("FAIL reset mem_addr got %0d expected 0", mem_addr);
        end
        rst = 1'b1;
    endtask

    task automatic test_reset_mid();
        for (int t = 0; t <= 6; t++) begin
            @(posedge clk);
            #1;
            start     = (t == 0);
            base_addr = '0;
            row_len   = LW'(5);
            num_rows  = LW'(1);
            buf_ready = 1'b1;
        end
        #1;
        checks++;
        if (buf_wen !== 1'b1 || buf_din !== {2'b00, mem[1]}) begin
            errors++;
            $display("FAIL rst_mid pre_push got wen=%b din=%h expected wen=1 din=%h", buf_wen, buf_din, {2'b00, mem[1]});
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({mem_ren, buf_wen, busy, done} !== 4'b0000 || buf_din !== '0) begin
            errors++;
            $display("FAIL rst_mid outputs got ctrl=%b din=%h expected ctrl=0000 din=0",
                     {mem_ren, buf_wen, busy, done}, buf_din);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        for (int t = 0; t < 4; t++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({mem_ren, buf_wen, busy, done} !== 4'b0000) begin
                errors++;
                $display("FAIL rst_mid idle cycle %0d got %b expected 0000", t, {mem_ren, buf_wen, busy, done});
            end
        end
        test_stream("rst_replay", 0, 5, 1, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = DW'($urandom);
        mem[0] = DW'(161);
        mem[1] = DW'(190);
        mem[2] = DW'(-161);
        mem[3] = DW'(-81);
        mem[4] = DW'(50);
        test_reset();
        test_stream("basic", 0, 5, 1, 0, 0);
        test_stream("wrap", 30, 3, 2, 0, 0);
        test_stream("backpressure", 0, 5, 1, 1, 0);
        test_stream("single", 7, 1, 3, 0, 0);
        test_stream("zero_len", 3, 0, 4, 0, 0);
        test_stream("zero_rows", 3, 4, 0, 0, 0);
        test_reset_mid();
        test_stream("busy_start", 0, 5, 1, 0, 1);
        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < 32; i++) mem[i] = DW'($urandom);
            test_stream("random", $urandom_range(0, 31), $urandom_range(1, 5),
                        $urandom_range(1, 4), 2, 1'($urandom_range(0, 1)));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifmap_stream_writer.md
Name: ifmap_stream_writer

Overview:
- Producer end of the IFMap FIFO protocol: reads a row-major input feature map from a synchronous memory, tags each word with row-framing bits and pushes it into the IFMap circular_buffer.
- The Processing_element drains that buffer.
- Replaces hand-driven write stimulus with a reusable block in the PE array feed path.

Parameters:
DATA_WIDTH, 20, IFMap data width; the buffer word is DATA_WIDTH+2.
ADDR_WIDTH, 5, memory address width.
LEN_WIDTH, 5, width of row_len and num_rows.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; asynchronous, active-low (rst=0 resets)
start  in  1  begin a transfer; sampled only in IDLE
base_addr  in  ADDR_WIDTH  address of the first element; latched on start
row_len  in  LEN_WIDTH  elements per row; latched on start
num_rows  in  LEN_WIDTH  rows to send; latched on start
mem_ren  out  1  memory read enable
mem_addr  out  ADDR_WIDTH  memory read address
mem_rdata  in  DATA_WIDTH  read data, valid exactly one cycle after mem_ren
buf_ready  in  1  circular_buffer can accept a write this cycle
buf_wen  out  1  buffer write enable
buf_din  out  DATA_WIDTH+2  {tag[1:0], data}
busy  out  1  transfer in progress
done  out  1  one-cycle pulse after the last write

Behaviour:
- Reset (rst=0, asynchronous): FSM goes to IDLE. Counters, hold register and all outputs clear to 0. A transfer in flight is abandoned and no further writes are issued. Resume after rst=1 requires a new start.
- FSM states: IDLE, READ, LOAD, PUSH, DONE.
- IDLE:
  - start=1 latches base_addr, row_len and num_rows, and clears the row and column counters.
  - If row_len==0 or num_rows==0, go to DONE with no memory reads and no writes. Otherwise go to READ.
  - start is ignored in every other state.
- READ: mem_ren=1 and mem_addr=cur_addr for exactly one cycle, then go to LOAD.
- LOAD: mem_rdata is captured into the hold register, then go to PUSH.
- PUSH:
  - buf_din={tag, hold} and buf_wen=buf_ready, both combinational.
  - If buf_ready=0, stay in PUSH with buf_din stable; nothing is lost and there is no timeout.
  - If buf_ready=1, the write is taken on this edge. Advance the counters, then go to READ, or to DONE if this was the last element.
- DONE: done=1 for one cycle, then go to IDLE.
- busy=1 in READ, LOAD and PUSH; 0 in IDLE and DONE.
- Tag per element, where col is the 0-based column within its row:
  - 2'b10 when col==0 and row_len>1 (first of row).
  - 2'b01 when col==row_len-1 and row_len>1 (last of row).
  - 2'b11 when row_len==1 (single-element row).
  - 2'b00 otherwise.
- Addressing: cur_addr starts at base_addr and increments by 1 per written element, wrapping modulo 2^ADDR_WIDTH.
- Counters:
  - col wraps to 0 at row_len-1, and row increments at that point.
  - The last element is row==num_rows-1 and col==row_len-1.
- Data passes through unmodified; signed values are opaque bits.
- Latency and throughput:
  - start asserted in cycle 0 gives mem_ren in cycle 1 and the first buf_wen in cycle 3 (with buf_ready=1).
  - One element per 3 cycles when unstalled; every cycle of buf_ready=0 in PUSH adds one cycle.
  - done arrives one cycle after the last write.
- buf_wen is never asserted while buf_ready=0, so the buffer is never overflowed.

Decomposition:
- Shared package holds:
  - Tag constants TAG_MID=2'b00, TAG_LAST=2'b01, TAG_FIRST=2'b10, TAG_SINGLE=2'b11, also used by the Processing_element decode.
  - FSM state encoding.
- One natural sub-module: ifmap_tag_counter, holding the row/col counters, last-element detect and tag generation.
- The top level contains the FSM, address register and hold register.

Test Plan:
- mem[0..4]=161,190,-161,-81,50, base=0, row_len=5, num_rows=1, buf_ready=1 → buffer receives {10,161},{00,190},{00,-161},{00,-81},{01,50} in cycles 3,6,9,12,15. done=1 in cycle 16; busy high in cycles 1–15.
- row_len=3, num_rows=2, base=30 (ADDR_WIDTH=5) → addresses 30,31,0,1,2,3 with tags 10,00,01,10,00,01; checks address wrap-around.
- Backpressure: same as the first scenario, but buf_ready=0 for cycles 6–9 → word 190 is held stable on buf_din with buf_wen=0 and is written in cycle 10. All later writes shift by 4 cycles; no loss and no duplicates.
- row_len=1, num_rows=3 → three writes, all tagged 11. row_len=0 → done pulse in cycle 1, with no mem_ren and no buf_wen.
- Reset mid-transfer: assert rst=0 during the PUSH of word 2 → outputs go to 0 immediately. After release, start is ignored until IDLE is reached (immediate), and a fresh start replays from base_addr.
- start pulsed again while busy → ignored; the transfer count and done timing are unchanged.
